fifo_ptr_ctrl: RTL
==================

// Module: fifo_ptr_ctrl
// PURPOSE
//  Single-clock FIFO pointer controller. Sequences write/read accesses to an
//  external 2**ADDR_W-entry RAM. Outputs binary RAM addresses, registered
//  Gray-coded pointers (for status export and later CDC reuse), occupancy and
//  status flags. Sits between producer/consumer handshakes and the FIFO RAM.
// PARAMETERS
//  ADDR_W     4  RAM address width; DEPTH = 2**ADDR_W; pointers are ADDR_W+1 bits
//  AF_MARGIN  1  almost_full asserts when count >= DEPTH-AF_MARGIN (0..DEPTH-1)
// PORTS
//  clk          in   1         clock, all state on rising edge
//  rst          in   1         synchronous reset, active-high
//  flush        in   1         synchronous pointer clear
//  wr_en        in   1         write request
//  rd_en        in   1         read request
//  wr_ack       out  1         write accepted this cycle (RAM write enable)
//  rd_ack       out  1         read accepted this cycle (RAM read enable)
//  wr_addr      out  ADDR_W    RAM write address = wr_ptr[ADDR_W-1:0]
//  rd_addr      out  ADDR_W    RAM read address  = rd_ptr[ADDR_W-1:0]
//  wr_ptr_gray  out  ADDR_W+1  registered Gray code of wr_ptr
//  rd_ptr_gray  out  ADDR_W+1  registered Gray code of rd_ptr
//  count        out  ADDR_W+1  occupancy, 0..DEPTH
//  full         out  1         count == DEPTH
//  empty        out  1         count == 0
//  almost_full  out  1         count >= DEPTH-AF_MARGIN
//  wr_ovf       out  1         1-cycle pulse: wr_en while full and not accepted
//  rd_udf       out  1         1-cycle pulse: rd_en while empty
// BEHAVIOUR
//  - Reset (rst=1 at edge): wr_ptr=rd_ptr=0, both Gray=0, count=0, empty=1,
//    full=0, almost_full=0 (unless DEPTH-AF_MARGIN==0), wr_ovf=rd_udf=0.
//    Reset mid-operation discards contents; the accept of that cycle is void.
//  - wr_ack = wr_en & ~full & ~flush & ~rst; rd_ack = rd_en & ~empty & ~flush
//    & ~rst. Both are combinational from the current registered state.
//  - On wr_ack, wr_ptr <= wr_ptr+1 mod 2**(ADDR_W+1); likewise rd_ack/rd_ptr.
//  - Gray registers load gray(next pointer) on the same edge, so binary and
//    Gray views always match; gray(x) = x ^ (x>>1). Consecutive values differ
//    in exactly one bit, including at wrap 2**(ADDR_W+1)-1 -> 0.
//  - count = wr_ptr - rd_ptr (mod 2**(ADDR_W+1)); full = MSBs differ and
//    low ADDR_W bits equal; empty = pointers equal. Flags are combinational from
//    the pointer registers: they reflect an accepted access one cycle after
//    the accepting edge.
//  - Simultaneous wr_en & rd_en: not empty and not full -> both accepted,
//    count unchanged. Full -> read accepted, write rejected (wr_ovf=1).
//    Empty -> write accepted, read rejected (rd_udf=1); no fall-through.
//  - flush=1: both pointers and Gray registers <- 0 next edge, no acks, no
//    ovf/udf pulses; rst has priority over flush.
//  - wr_ovf/rd_udf are registered pulses, asserted the cycle after the
//    offending request.
// STRUCTURE
//  - Shared package fifo_pkg: localparam DEPTH derivation, gray() function.
//  - Sub-module: existing Bin_to_Gray (len=ADDR_W+1), two instances
//    converting next wr/rd pointer values ahead of the Gray registers.
//  - Pointer/flag logic stays in this module; no FSM beyond the pointers.
// TESTING (ADDR_W=2, AF_MARGIN=1, DEPTH=4)
//  - Reset: rst=1 then 0 -> count=0, empty=1, full=0, all pointers/Gray=0.
//  - Fill: 4 single writes -> count 1..4, almost_full=1 at count=3, full=1;
//    wr_ptr_gray=3'b110.
//  - Overflow: 5th write while full -> wr_ack=0, wr_ovf pulse next cycle,
//    wr_ptr unchanged. wr_en+rd_en while full -> rd_ack=1, wr_ack=0, count=3.
//  - Underflow: rd_en when empty -> rd_ack=0, rd_udf pulse; wr+rd when empty
//    -> count=1.
//  - Wrap: 9 write/read pairs -> wr_ptr_gray sequence 000,001,011,010,110,
//    111,101,100,000; 1 bit changes per step; rd_addr wraps 3->0.
//  - Flush with count=3 and wr_en=1 -> no ack, next cycle count=0, empty=1,
//    Gray=0; rst and flush together -> reset values.

Source files
------------

// File: rtl/fifo_ptr_ctrl_pkg.sv
// Shared definitions for the FIFO pointer controller:
// default sizing, depth derivation and Gray encoding.
package fifo_pkg;

   localparam int DEF_ADDR_W    = 4;
   localparam int DEF_AF_MARGIN = 1;

   function automatic int fifo_depth(input int addr_w);
      return 1 << addr_w;
   endfunction

   function automatic logic [31:0] gray(input logic [31:0] x);
      return x ^ (x >> 1);
   endfunction

endpackage

// File: rtl/fifo_ptr_ctrl_if.sv
// Producer/consumer request side and RAM/status side of the
// FIFO pointer controller.
interface fifo_ptr_ctrl_if #(
   parameter int ADDR_W = 4
);

   logic              flush;
   logic              wr_en;
   logic              rd_en;
   logic              wr_ack;
   logic              rd_ack;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W:0]   wr_ptr_gray;
   logic [ADDR_W:0]   rd_ptr_gray;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              wr_ovf;
   logic              rd_udf;

   modport master (
      output flush, wr_en, rd_en,
      input  wr_ack, rd_ack, wr_addr, rd_addr,
      input  wr_ptr_gray, rd_ptr_gray, count,
      input  full, empty, almost_full, wr_ovf, rd_udf
   );

   modport slave (
      input  flush, wr_en, rd_en,
      output wr_ack, rd_ack, wr_addr, rd_addr,
      output wr_ptr_gray, rd_ptr_gray, count,
      output full, empty, almost_full, wr_ovf, rd_udf
   );

endinterface

// File: rtl/fifo_ptr_ctrl_bin_to_gray.sv
// Combinational binary to Gray converter, len bits wide
// (len must not exceed 32).
module Bin_to_Gray
   import fifo_pkg::*;
#(
   parameter int len = 5
) (
   input  logic [len-1:0] bin_i,
   output logic [len-1:0] gray_o
);

   assign gray_o = len'(gray(32'(bin_i)));

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Single-clock FIFO pointer controller: RAM addresses, registered
// Gray pointers, occupancy and status flags.
module fifo_ptr_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int AF_MARGIN = DEF_AF_MARGIN
) (
   input  logic           clk,
   input  logic           rst,
   fifo_ptr_ctrl_if.slave bus
);

   localparam int PW    = ADDR_W + 1;
   localparam int DEPTH = fifo_depth(ADDR_W);
   localparam logic [PW-1:0] AF_THR = PW'(DEPTH - AF_MARGIN);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_gray_q, wr_gray_d;
   logic [PW-1:0] rd_gray_q, rd_gray_d;
   logic          wr_ovf_q, wr_ovf_d;
   logic          rd_udf_q, rd_udf_d;
   logic [PW-1:0] count;
   logic          full, empty;
   logic          wr_ack, rd_ack;

   // Extra pointer MSB separates full from empty when low bits match.
   assign count = wr_ptr_q - rd_ptr_q;
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                  (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

   assign wr_ack = bus.wr_en & ~full  & ~bus.flush & ~rst;
   assign rd_ack = bus.rd_en & ~empty & ~bus.flush & ~rst;

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(wr_ack);
      rd_ptr_d = rd_ptr_q + PW'(rd_ack);
      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end
   end

   assign wr_ovf_d = bus.wr_en & full  & ~bus.flush;
   assign rd_udf_d = bus.rd_en & empty & ~bus.flush;

   // Convert next values so Gray and binary load on the same edge.
   Bin_to_Gray #(.len(PW)) u_wr_gray (
      .bin_i  (wr_ptr_d),
      .gray_o (wr_gray_d)
   );

   Bin_to_Gray #(.len(PW)) u_rd_gray (
      .bin_i  (rd_ptr_d),
      .gray_o (rd_gray_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         wr_gray_q <= '0;
         rd_gray_q <= '0;
         wr_ovf_q  <= 1'b0;
         rd_udf_q  <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_gray_q <= wr_gray_d;
         rd_gray_q <= rd_gray_d;
         wr_ovf_q  <= wr_ovf_d;
         rd_udf_q  <= rd_udf_d;
      end
   end

   assign bus.wr_ack      = wr_ack;
   assign bus.rd_ack      = rd_ack;
   assign bus.wr_addr     = wr_ptr_q[ADDR_W-1:0];
   assign bus.rd_addr     = rd_ptr_q[ADDR_W-1:0];
   assign bus.wr_ptr_gray = wr_gray_q;
   assign bus.rd_ptr_gray = rd_gray_q;
   assign bus.count       = count;
   assign bus.full        = full;
   assign bus.empty       = empty;
   assign bus.almost_full = (count >= AF_THR);
   assign bus.wr_ovf      = wr_ovf_q;
   assign bus.rd_udf      = rd_udf_q;

endmodule
